// File: rtl/quad_sine_nco_if.sv
// Control and sample bus of the quadrature NCO; the driver holds the master side.
// Inputs are sampled on clk; outputs change on clk and flow only on en_i cycles.
interface quad_sine_nco_if #(
    parameter int PHASE_W = 24,
    parameter int DW      = 16
);
    logic                 en_i;
    logic [PHASE_W-1:0]   freq_i;
    logic                 freq_load_i;
    logic [PHASE_W-1:0]   phase_ofs_i;
    logic                 sync_i;
    logic signed [DW-1:0] sin_o;
    logic signed [DW-1:0] cos_o;
    logic                 valid_o;

    modport master (
        output en_i, freq_i, freq_load_i, phase_ofs_i, sync_i,
        input  sin_o, cos_o, valid_o
    );

    modport slave (
        input  en_i, freq_i, freq_load_i, phase_ofs_i, sync_i,
        output sin_o, cos_o, valid_o
    );
endinterface

// File: rtl/quad_sine_nco.sv
// Quadrature sine/cosine NCO: accumulator, offset + quarter-wave fold, dual-port ROM, sign restore.
// Accumulator value reaches sin_o/cos_o 3 enabled cycles later; en_i = 0 stalls every stage.
module quad_sine_nco #(
    parameter int PHASE_W   = 24,
    parameter int ADDR_BITS = 10,
    parameter int DW        = 16
) (
    input  logic clk,
    input  logic rst,
    quad_sine_nco_if.slave nco
);
    localparam int QA   = ADDR_BITS - 2;
    localparam int QN   = 1 << QA;
    localparam int PEAK = (1 << (DW - 1)) - 1;

    // Half-step sample points make entry i mirror entry QN-1-i exactly, so the
    // bit-inverted index folds quadrants 1 and 3 without an off-by-one.
    function automatic logic [DW-1:0] rom_entry(input int i);
        real x;
        x = real'(PEAK) * $sin((real'(i) + 0.5) * 3.14159265358979323846
                               / real'(1 << (ADDR_BITS - 1)));
        return DW'($rtoi(x + 0.5));
    endfunction

    logic [DW-1:0] rom [QN];
    for (genvar g = 0; g < QN; g++) begin : g_rom
        assign rom[g] = rom_entry(g);
    end

    logic [PHASE_W-1:0]   inc_q, acc_q, acc_d;
    logic [PHASE_W-1:0]   phase;
    logic [ADDR_BITS-1:0] taddr_s, taddr_c;
    logic [QA-1:0]        sin_idx_d, cos_idx_d, sin_idx_q, cos_idx_q;
    logic                 sin_neg1_q, cos_neg1_q, sin_neg2_q, cos_neg2_q;
    logic [DW-1:0]        sin_mag_q, cos_mag_q;
    logic signed [DW-1:0] sin_q, cos_q;
    logic [1:0]           fill_q;
    logic                 valid_q;

    always_comb begin
        acc_d = acc_q + inc_q;
        if (nco.sync_i) acc_d = '0;
    end

    assign phase     = acc_q + nco.phase_ofs_i;
    assign taddr_s   = ADDR_BITS'(phase >> (PHASE_W - ADDR_BITS));
    assign taddr_c   = taddr_s + ADDR_BITS'(QN);
    assign sin_idx_d = taddr_s[QA-1:0] ^ {QA{taddr_s[QA]}};
    assign cos_idx_d = taddr_c[QA-1:0] ^ {QA{taddr_c[QA]}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inc_q <= '0;
        end else if (nco.freq_load_i) begin
            inc_q <= nco.freq_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q      <= '0;
            sin_idx_q  <= '0;
            cos_idx_q  <= '0;
            sin_neg1_q <= 1'b0;
            cos_neg1_q <= 1'b0;
            sin_mag_q  <= '0;
            cos_mag_q  <= '0;
            sin_neg2_q <= 1'b0;
            cos_neg2_q <= 1'b0;
            sin_q      <= '0;
            cos_q      <= '0;
            fill_q     <= 2'd0;
        end else if (nco.en_i) begin
            acc_q      <= acc_d;
            sin_idx_q  <= sin_idx_d;
            cos_idx_q  <= cos_idx_d;
            sin_neg1_q <= taddr_s[ADDR_BITS-1];
            cos_neg1_q <= taddr_c[ADDR_BITS-1];
            sin_mag_q  <= rom[sin_idx_q];
            cos_mag_q  <= rom[cos_idx_q];
            sin_neg2_q <= sin_neg1_q;
            cos_neg2_q <= cos_neg1_q;
            sin_q      <= sin_neg2_q ? -sin_mag_q : sin_mag_q;
            cos_q      <= cos_neg2_q ? -cos_mag_q : cos_mag_q;
            if (fill_q != 2'd3) fill_q <= fill_q + 2'd1;
        end
    end

    // Updated every edge so a stalled cycle reports no new sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) valid_q <= 1'b0;
        else      valid_q <= nco.en_i && (fill_q == 2'd3);
    end

    assign nco.sin_o   = sin_q;
    assign nco.cos_o   = cos_q;
    assign nco.valid_o = valid_q;
endmodule
